// File: rtl/change_logger_pkg.sv
// Shared defaults and helpers for the change logger: bus widths, FIFO depth
// and the wrapping timestamp increment.
package change_logger_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TS_WIDTH_DEF   = 16;
  localparam int DEPTH_DEF      = 8;

  // Increment a timestamp of 'width' bits (1..32), wrapping to 0 silently.
  function automatic logic [31:0] next_ts(input logic [31:0] ts, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (ts + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/change_logger_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; the head reads as zero
// while empty. A push into a full FIFO is taken only when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset: stale slots are hidden by the count and head gating.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/change_logger.sv
// Event monitor: logs {timestamp, new value} for every change of d_i while
// enabled, and streams the log out over a valid/ready port.
module change_logger
  import change_logger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [DATA_WIDTH-1:0]    d_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [DATA_WIDTH-1:0]    m_data_o,
  output logic [TS_WIDTH-1:0]      m_ts_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int EW = TS_WIDTH + DATA_WIDTH;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  overflow_q, overflow_d;
  logic                  change, pop, fifo_full, fifo_empty;
  logic [EW-1:0]         head;

  assign change = en_i && (d_i != prev_q);
  assign pop    = !fifo_empty && m_ready_i;

  always_comb begin
    ts_d       = en_i ? TS_WIDTH'(next_ts(32'(ts_q), TS_WIDTH)) : ts_q;
    prev_d     = d_i;
    // A change is lost only when full and nothing leaves in the same cycle.
    overflow_d = overflow_q || (change && fifo_full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (change),
    .wdata_i ({ts_q, d_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign m_valid_o  = !fifo_empty;
  assign m_data_o   = head[DATA_WIDTH-1:0];
  assign m_ts_o     = head[EW-1 -: TS_WIDTH];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_change_logger.sv
// Directed bench for change_logger: reset, streaming, backpressure/overflow,
// full push+pop, timestamp wrap (4-bit instance) and enable/reset handling.
module tb_change_logger;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic [7:0]  d;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] m_ts;
  logic [3:0]  m_count;
  logic        ovf;

  logic        rst2, en2, ready2;
  logic [7:0]  d2;
  logic        m_valid2;
  logic [7:0]  m_data2;
  logic [3:0]  m_ts2;
  logic [3:0]  m_count2;
  logic        ovf2;

  int          checks = 0;
  int          passed = 0;
  logic [15:0] ts_exp = 16'd0;
  logic [15:0] tsl [9];

  always #5 clk = ~clk;

  change_logger dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d),
    .m_valid_o(m_valid), .m_ready_i(ready), .m_data_o(m_data), .m_ts_o(m_ts),
    .count_o(m_count), .overflow_o(ovf)
  );

  change_logger #(.DATA_WIDTH(8), .TS_WIDTH(4), .DEPTH(8)) dut_wrap (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .d_i(d2),
    .m_valid_o(m_valid2), .m_ready_i(ready2), .m_data_o(m_data2), .m_ts_o(m_ts2),
    .count_o(m_count2), .overflow_o(ovf2)
  );

  // One rising edge; returns on the following falling edge. ts_exp tracks the
  // timestamp the main DUT holds during the cycle about to be driven.
  task automatic step();
    @(posedge clk);
    if (rst) ts_exp = 16'd0;
    else if (en) ts_exp = ts_exp + 16'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; d = 8'd0; ready = 1'b0;
    step(); step();
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else passed++;
    checks++; if (m_count !== 4'd0) $display("FAIL reset_count got %0d want 0", m_count); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
    checks++; if (m_ts !== 16'd0) $display("FAIL reset_ts got %0d want 0", m_ts); else passed++;
    checks++; if (m_data !== 8'd0) $display("FAIL reset_data got %0d want 0", m_data); else passed++;
    $display("reset: valid=%b count=%0d ovf=%b", m_valid, m_count, ovf);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] t0;
    en = 1'b1; ready = 1'b1;
    t0 = ts_exp;
    for (int k = 0; k <= 9; k++) begin
      d = 8'(k);
      step();
      if (k == 0) begin
        checks++; if (m_count !== 4'd0) $display("FAIL stream_zero_count got %0d want 0", m_count); else passed++;
      end else begin
        checks++; if (m_valid !== 1'b1) $display("FAIL stream_valid k=%0d got %b want 1", k, m_valid); else passed++;
        checks++; if (m_data !== 8'(k)) $display("FAIL stream_data k=%0d got %0d want %0d", k, m_data, k); else passed++;
        checks++; if (m_ts !== t0 + 16'(k)) $display("FAIL stream_ts k=%0d got %0d want %0d", k, m_ts, t0 + 16'(k)); else passed++;
        checks++; if (m_count !== 4'd1) $display("FAIL stream_count k=%0d got %0d want 1", k, m_count); else passed++;
      end
      $display("stream: d=%0d valid=%b data=%0d ts=%0d count=%0d", k, m_valid, m_data, m_ts, m_count);
    end
    step();
    checks++; if (m_count !== 4'd0) $display("FAIL stream_drained got %0d want 0", m_count); else passed++;
    step();
    checks++; if (m_valid !== 1'b0 || m_count !== 4'd0) $display("FAIL ready_empty got valid=%b count=%0d want 0/0", m_valid, m_count); else passed++;
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      d = 8'(10 + k);
      tsl[k] = ts_exp;
      step();
      if (k == 7) begin
        checks++; if (m_count !== 4'd8 || ovf !== 1'b0) $display("FAIL bp_full got count=%0d ovf=%b want 8/0", m_count, ovf); else passed++;
      end
      $display("bp_fill: d=%0d count=%0d ovf=%b", 10 + k, m_count, ovf);
    end
    checks++; if (m_count !== 4'd8) $display("FAIL bp_drop_count got %0d want 8", m_count); else passed++;
    checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf got %b want 1", ovf); else passed++;
    // Head must hold steady while stalled.
    step();
    checks++; if (m_data !== 8'd10 || m_ts !== tsl[0]) $display("FAIL bp_stall got %0d@%0d want 10@%0d", m_data, m_ts, tsl[0]); else passed++;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 8'(10 + i)) $display("FAIL bp_drain_data i=%0d got %0d want %0d", i, m_data, 10 + i); else passed++;
      checks++; if (m_ts !== tsl[i]) $display("FAIL bp_drain_ts i=%0d got %0d want %0d", i, m_ts, tsl[i]); else passed++;
      $display("bp_drain: data=%0d ts=%0d count=%0d", m_data, m_ts, m_count);
      step();
    end
    checks++; if (m_count !== 4'd0 || m_valid !== 1'b0) $display("FAIL bp_empty got count=%0d valid=%b want 0/0", m_count, m_valid); else passed++;
    checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf_sticky got %b want 1", ovf); else passed++;
  endtask

  task automatic test_full_push_pop();
    rst = 1'b1; d = 8'd0; ready = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (ovf !== 1'b0) $display("FAIL fpp_ovf_cleared got %b want 0", ovf); else passed++;
    for (int k = 1; k <= 8; k++) begin
      d = 8'(k);
      step();
    end
    checks++; if (m_count !== 4'd8) $display("FAIL fpp_full got %0d want 8", m_count); else passed++;
    d = 8'd9; ready = 1'b1;
    step();
    checks++; if (m_count !== 4'd8) $display("FAIL fpp_count got %0d want 8", m_count); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL fpp_ovf got %b want 0", ovf); else passed++;
    $display("full_push_pop: count=%0d ovf=%b head=%0d", m_count, ovf, m_data);
    // Entries 2..9 were logged at timestamps 1..8 after the reset.
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_data !== 8'(2 + i) || m_ts !== 16'(i + 1)) $display("FAIL fpp_drain i=%0d got %0d@%0d want %0d@%0d", i, m_data, m_ts, 2 + i, i + 1); else passed++;
      step();
    end
    checks++; if (m_count !== 4'd0) $display("FAIL fpp_empty got %0d want 0", m_count); else passed++;
  endtask

  task automatic test_enable_reset();
    logic [15:0] tsf;
    ready = 1'b0;
    tsf = ts_exp;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = 8'(20 + k);
      step();
      checks++; if (m_count !== 4'd0) $display("FAIL en_off_count k=%0d got %0d want 0", k, m_count); else passed++;
    end
    en = 1'b1;
    step();
    checks++; if (m_count !== 4'd0) $display("FAIL en_steady got %0d want 0", m_count); else passed++;
    d = 8'd23;
    step();
    checks++; if (m_count !== 4'd1 || m_data !== 8'd23) $display("FAIL en_change got count=%0d data=%0d want 1/23", m_count, m_data); else passed++;
    checks++; if (m_ts !== tsf + 16'd1) $display("FAIL en_ts_frozen got %0d want %0d", m_ts, tsf + 16'd1); else passed++;
    d = 8'd24; step();
    d = 8'd25; step();
    checks++; if (m_count !== 4'd3) $display("FAIL en_pending got %0d want 3", m_count); else passed++;
    rst = 1'b1;
    step();
    checks++; if (m_valid !== 1'b0 || m_count !== 4'd0) $display("FAIL midreset got valid=%b count=%0d want 0/0", m_valid, m_count); else passed++;
    checks++; if (m_data !== 8'd0 || m_ts !== 16'd0) $display("FAIL midreset_head got %0d@%0d want 0@0", m_data, m_ts); else passed++;
    rst = 1'b0;
    step();
    checks++; if (m_count !== 4'd1 || m_data !== 8'd25 || m_ts !== 16'd0) $display("FAIL restart got count=%0d data=%0d ts=%0d want 1/25/0", m_count, m_data, m_ts); else passed++;
    $display("enable_reset: restart entry data=%0d ts=%0d", m_data, m_ts);
  endtask

  task automatic test_wrap();
    rst2 = 1'b1; en2 = 1'b1; d2 = 8'd0; ready2 = 1'b0;
    step(); step();
    rst2 = 1'b0;
    for (int c = 0; c < 17; c++) step();
    checks++; if (m_count2 !== 4'd0) $display("FAIL wrap_idle got %0d want 0", m_count2); else passed++;
    d2 = 8'd5;
    step();
    checks++; if (m_valid2 !== 1'b1 || m_data2 !== 8'd5) $display("FAIL wrap_data got valid=%b data=%0d want 1/5", m_valid2, m_data2); else passed++;
    checks++; if (m_ts2 !== 4'd1) $display("FAIL wrap_ts got %0d want 1", m_ts2); else passed++;
    $display("wrap: data=%0d ts=%0d", m_data2, m_ts2);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = 8'd0; ready = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; d2 = 8'd0; ready2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_enable_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
